// File: rtl/trig_pkg.sv
// -----------------------------------------------------------------------------
// trig_pkg
// Shared declarations for the two-source trigger decoder: source-mask width,
// FSM state encoding and the queued record layout (default 32-bit timestamp).
// -----------------------------------------------------------------------------
package trig_pkg;

  localparam int unsigned SRC_W    = 2;
  localparam int unsigned TS_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PUSH    = 2'd2
  } state_e;

  typedef struct packed {
    logic [SRC_W-1:0]    src;
    logic [TS_W_DEF-1:0] ts;
  } rec_t;

endpackage

// File: rtl/trig_rec_fifo.sv
// -----------------------------------------------------------------------------
// trig_rec_fifo
// First-word-fall-through record FIFO. The head entry is presented on data_o
// whenever valid_o is high; data_o reads as zero while empty.
// Ports:
//   clk_i     clock
//   rst_ni    synchronous active-low reset (empties the FIFO)
//   push_i    write request, data_i is the word to store
//   pop_i     consumer ready; a pop happens only when valid_o is high
//   data_o    head word (zero when empty)
//   valid_o   FIFO not empty
//   accept_o  push_i was accepted this cycle (not full, or popping)
// -----------------------------------------------------------------------------
module trig_rec_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             accept_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty, full, pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop      = pop_i & ~empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign accept_o = push_i & (~full | pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (accept_o) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop)      rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept_o) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign valid_o = ~empty;
  assign data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/trig_source_decoder.sv
// -----------------------------------------------------------------------------
// trig_source_decoder
// Recovers which trigger source(s) caused each merged event. Each event becomes
// a record {source mask, timestamp at first edge} queued in a FWFT FIFO.
// Ports:
//   s00_axi_aclk     clock
//   s00_axi_aresetn  synchronous active-low reset
//   signal1/signal2  asynchronous trigger levels (mask bit0 / bit1)
//   ts_count         free-running timestamp, latched at the first edge
//   merged_evt       one-cycle pulse at the start of each event
//   rec_valid        a record is available at the FIFO head
//   rec_ready        consumer accepts the head record
//   rec_src/rec_ts   head record (zero when no record is queued)
//   overflow         sticky: a record was dropped on a full FIFO
//   overflow_clr     clears overflow (a same-cycle drop keeps it set)
// -----------------------------------------------------------------------------
module trig_source_decoder
  import trig_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned WINDOW     = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 s00_axi_aclk,
  input  logic                 s00_axi_aresetn,
  input  logic                 signal1,
  input  logic                 signal2,
  input  logic [CNT_WIDTH-1:0] ts_count,
  output logic                 merged_evt,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [1:0]           rec_src,
  output logic [CNT_WIDTH-1:0] rec_ts,
  output logic                 overflow,
  input  logic                 overflow_clr
);

  localparam int unsigned WCW   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned REC_W = SRC_W + CNT_WIDTH;

  logic [SRC_W-1:0]     sync1_q, sync2_q, prev_q;
  logic [1:0]           arm_cnt_q;
  logic [SRC_W-1:0]     e;

  state_e               state_q, state_d;
  logic [WCW-1:0]       win_cnt_q, win_cnt_d;
  logic [SRC_W-1:0]     mask_q, mask_d;
  logic [CNT_WIDTH-1:0] ts_lat_q, ts_lat_d;
  logic                 start, push, push_ok;
  logic                 merged_evt_q, overflow_q;
  logic [REC_W-1:0]     head;

  // Synchronizer, edge history and post-reset arming counter
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      arm_cnt_q <= '0;
    end else begin
      sync1_q <= {signal2, signal1};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (arm_cnt_q != 2'd3) arm_cnt_q <= arm_cnt_q + 2'd1;
    end
  end

  // Edges are suppressed for three cycles after reset so a level already high
  // at release is not mistaken for a fresh trigger.
  assign e = (arm_cnt_q == 2'd3) ? (sync2_q & ~prev_q) : '0;

  // FSM state register
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    mask_q   <= mask_d;
    ts_lat_q <= ts_lat_d;
  end

  // FSM outputs: a new event may open from IDLE or straight out of PUSH
  always_comb begin
    push  = (state_q == PUSH);
    start = ((state_q == IDLE) || (state_q == PUSH)) && (|e);
  end

  // FSM next state
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    mask_d    = mask_q;
    ts_lat_d  = ts_lat_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      COLLECT: begin
        mask_d = mask_q | e;
        if (win_cnt_q == '0) state_d = PUSH;
        else                 win_cnt_d = win_cnt_q - WCW'(1);
      end
      PUSH:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d   = COLLECT;
      mask_d    = e;
      ts_lat_d  = ts_count;
      win_cnt_d = WCW'(WINDOW - 1);
    end
  end

  // Registered event pulse and sticky overflow
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      merged_evt_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      merged_evt_q <= start;
      if (push && !push_ok) overflow_q <= 1'b1;
      else if (overflow_clr) overflow_q <= 1'b0;
    end
  end

  trig_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (s00_axi_aclk),
    .rst_ni   (s00_axi_aresetn),
    .push_i   (push),
    .data_i   ({mask_q, ts_lat_q}),
    .pop_i    (rec_ready),
    .data_o   (head),
    .valid_o  (rec_valid),
    .accept_o (push_ok)
  );

  assign rec_src    = head[REC_W-1 -: SRC_W];
  assign rec_ts     = head[CNT_WIDTH-1:0];
  assign merged_evt = merged_evt_q;
  assign overflow   = overflow_q;

endmodule
